// File: rtl/router_pkt_register.sv
// Datapath register between the 1x3 router FSM and the output FIFOs.
// Forwards header/payload/parity bytes, buffers bytes while the FIFO is full, and checks parity and length.
module router_pkt_register #(
  parameter int DATA_WIDTH = 8,
  parameter int HOLD_DEPTH = 4,
  parameter int ADDR_BITS  = 2,
  localparam int CW = $clog2(HOLD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  rst_int_reg,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic                  len_err,
  output logic                  ovf_err,
  output logic [CW-1:0]         hold_count,
  output logic                  hold_full
);

  localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(HOLD_DEPTH - 1);

  logic [DATA_WIDTH-1:0] hold_header, int_parity, packt_parity, byte_cnt, hdr_len;
  logic [DATA_WIDTH-1:0] buf_data [HOLD_DEPTH];
  logic                  buf_tag  [HOLD_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count_nxt;
  logic                  header, load, buf_empty;
  logic                  do_pop, do_push, do_drop, out_en, out_last;
  logic [DATA_WIDTH-1:0] out_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign hdr_len = DATA_WIDTH'(hold_header[DATA_WIDTH-1:ADDR_BITS]);

  // Handshake: dout_valid is a one-cycle FIFO write strobe with no ready; dout is
  // consumed in every cycle it is high. fifo_full is honoured by holding bytes here.
  always_comb begin
    header    = detect_add && pkt_valid;
    load      = ld_state && !full_state;
    buf_empty = (hold_count == '0);
    do_pop    = 1'b0;
    do_push   = 1'b0;
    do_drop   = 1'b0;
    out_en    = 1'b0;
    out_last  = 1'b0;
    out_data  = dout;
    if (lfd_state) begin
      out_en   = 1'b1;
      out_data = hold_header;
    end else if (load) begin
      if (!fifo_full && buf_empty) begin
        out_en   = 1'b1;
        out_data = data_in;
        out_last = !pkt_valid;
      end else if (!fifo_full) begin
        do_pop  = 1'b1;
        do_push = 1'b1;
      end else if (hold_full) begin
        do_drop = 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end else if (laf_state && !fifo_full && !buf_empty) begin
      do_pop = 1'b1;
    end
    if (do_pop) begin
      out_en   = 1'b1;
      out_data = buf_data[rd_ptr];
      out_last = buf_tag[rd_ptr];
    end
  end

  always_comb begin
    case ({do_push, do_pop})
      2'b10:   count_nxt = hold_count + CW'(1);
      2'b01:   count_nxt = hold_count - CW'(1);
      default: count_nxt = hold_count;
    endcase
  end

  // Entries are {last_tag, data}; occupancy is tracked by hold_count, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      buf_data[wr_ptr] <= data_in;
      buf_tag[wr_ptr]  <= !pkt_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout          <= '0;
      dout_valid    <= 1'b0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
      ovf_err       <= 1'b0;
      hold_count    <= '0;
      hold_full     <= 1'b0;
      hold_header   <= '0;
      int_parity    <= '0;
      packt_parity  <= '0;
      byte_cnt      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else begin
      dout_valid  <= out_en;
      parity_done <= out_en && out_last;
      if (out_en) dout <= out_data;
      // The delivered parity byte is compared against the running parity of header and payload.
      if (out_en && out_last) begin
        err     <= (int_parity != out_data);
        len_err <= (byte_cnt != hdr_len);
      end
      if (header) begin
        hold_header <= data_in;
        int_parity  <= '0;
        byte_cnt    <= '0;
        ovf_err     <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        hold_count  <= '0;
        hold_full   <= 1'b0;
      end else begin
        if (lfd_state) int_parity <= int_parity ^ hold_header;
        if (load && pkt_valid) begin
          int_parity <= int_parity ^ data_in;
          byte_cnt   <= byte_cnt + DATA_WIDTH'(1);
        end
        if (load && !pkt_valid) packt_parity <= data_in;
        if (do_drop) ovf_err <= 1'b1;
        if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (do_push) wr_ptr <= ptr_inc(wr_ptr);
        hold_count <= count_nxt;
        hold_full  <= (count_nxt == CW'(HOLD_DEPTH));
      end
      if (rst_int_reg || detect_add) low_pkt_valid <= 1'b0;
      else if (load && !pkt_valid)   low_pkt_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_pkt_register.sv
// Bench for router_pkt_register: directed packets from the test plan plus randomized
// packets, checked against a queue-based packet model and packet-level parity/length rules.
module tb_router_pkt_register;
  localparam int DW   = 8;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          pkt_valid, fifo_full, rst_int_reg;
  logic          detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [DW-1:0] data_in;
  logic [DW-1:0] dout;
  logic          dout_valid, parity_done, low_pkt_valid, err, len_err, ovf_err, hold_full;
  logic [2:0]    hold_count;

  router_pkt_register #(.DATA_WIDTH(DW), .HOLD_DEPTH(HOLD), .ADDR_BITS(2)) dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .dout(dout), .dout_valid(dout_valid),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .err(err),
    .len_err(len_err), .ovf_err(ovf_err), .hold_count(hold_count), .hold_full(hold_full)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and model state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW:0]   hq[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] pl[$];
  logic [DW-1:0] m_hdr, m_dout;
  bit            m_ev, m_pd, m_lpv, m_err, m_len, m_ovf, m_pend_err, m_pend_len;
  int            pd_cnt, max_hold;
  bit [15:0]     ff_force;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    exp_q.delete();
    m_hdr = '0; m_dout = '0;
    m_ev = 0; m_pd = 0; m_lpv = 0; m_err = 0; m_len = 0; m_ovf = 0;
  endtask

  // Packet-level behaviour: hold queue of {last, byte}, FIFO order, drops when full.
  task automatic model_step();
    bit          em;
    logic [DW:0] ent, out;
    em = 0;
    out = '0;
    m_pd = 0;
    if (detect_add && pkt_valid) begin
      m_hdr = data_in;
      hq.delete();
      m_ovf = 0;
    end
    if (lfd_state) begin
      em = 1;
      out = {1'b0, m_hdr};
    end else if (ld_state && !full_state) begin
      ent = {!pkt_valid, data_in};
      if (!fifo_full) begin
        em = 1;
        if (hq.size() == 0) out = ent;
        else begin
          out = hq.pop_front();
          hq.push_back(ent);
        end
      end else if (hq.size() == HOLD) m_ovf = 1;
      else hq.push_back(ent);
    end else if (laf_state && !fifo_full && hq.size() > 0) begin
      em = 1;
      out = hq.pop_front();
    end
    m_ev = em;
    if (em) begin
      exp_q.push_back(out[DW-1:0]);
      if (out[DW]) begin
        m_pd  = 1;
        m_err = m_pend_err;
        m_len = m_pend_len;
      end
    end
    if (rst_int_reg || detect_add) m_lpv = 0;
    else if (ld_state && !full_state && !pkt_valid) m_lpv = 1;
  endtask

  task automatic check_outputs();
    if (m_ev) m_dout = exp_q.pop_front();
    check_eq("dout_valid", 32'(dout_valid), 32'(m_ev));
    check_eq("dout", 32'(dout), 32'(m_dout));
    check_eq("parity_done", 32'(parity_done), 32'(m_pd));
    check_eq("hold_count", 32'(hold_count), 32'(hq.size()));
    check_eq("hold_full", 32'(hold_full), 32'(hq.size() == HOLD));
    check_eq("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check_eq("low_pkt_valid", 32'(low_pkt_valid), 32'(m_lpv));
    check_eq("err", 32'(err), 32'(m_err));
    check_eq("len_err", 32'(len_err), 32'(m_len));
    if (dout_valid) obs_q.push_back(dout);
    if (parity_done) pd_cnt++;
    if (int'(hold_count) > max_hold) max_hold = int'(hold_count);
  endtask

  // driver tasks
  task automatic cyc(input bit da, input bit lfd, input bit ld, input bit laf, input bit fs,
                     input bit pv, input bit ff, input bit ri, input logic [DW-1:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf; full_state = fs;
    pkt_valid = pv; fifo_full = ff; rst_int_reg = ri; data_in = d;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr, input int ff_pct, input bit bad_par);
    logic [DW-1:0] par, eb;
    int            n, guard;
    bit            ff;
    n = pl.size();
    par = hdr;
    foreach (pl[i]) par ^= pl[i];
    if (bad_par) par ^= 8'h03;
    m_pend_err = bad_par;
    m_pend_len = (n != int'(hdr[DW-1:2]));
    obs_q.delete();
    pd_cnt = 0;
    max_hold = 0;
    cyc(1, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)), 0, hdr);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'($urandom));
    for (int i = 0; i <= n; i++) begin
      if (ff_pct > 0 && $urandom_range(0, 4) == 0) cyc(0, 0, 0, 0, 1, 1, 1, 0, 8'($urandom));
      ff = ff_force[i] || ($urandom_range(0, 99) < ff_pct);
      cyc(0, 0, 1, 0, 0, (i < n), ff, 0, (i < n) ? pl[i] : par);
    end
    guard = 0;
    while (hq.size() > 0 && guard < 100) begin
      ff = (ff_pct > 0) && ($urandom_range(0, 99) < 30);
      cyc(0, 0, 0, 1, 0, 0, ff, 0, 8'($urandom));
      guard++;
    end
    check_eq("drain_done", 32'(hold_count), 32'(0));
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 8'($urandom));
    if (!m_ovf) begin
      check_eq("stream_len", 32'(obs_q.size()), 32'(n + 2));
      if (obs_q.size() == n + 2) begin
        for (int i = 0; i < n + 2; i++) begin
          eb = (i == 0) ? hdr : (i <= n) ? pl[i-1] : par;
          check_eq("stream_byte", 32'(obs_q[i]), 32'(eb));
        end
      end
      check_eq("pd_count", 32'(pd_cnt), 32'(1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_dout"}, 32'(dout), 32'(0));
    check_eq({tag, "_dout_valid"}, 32'(dout_valid), 32'(0));
    check_eq({tag, "_parity_done"}, 32'(parity_done), 32'(0));
    check_eq({tag, "_low_pkt_valid"}, 32'(low_pkt_valid), 32'(0));
    check_eq({tag, "_err"}, 32'(err), 32'(0));
    check_eq({tag, "_len_err"}, 32'(len_err), 32'(0));
    check_eq({tag, "_ovf_err"}, 32'(ovf_err), 32'(0));
    check_eq({tag, "_hold_count"}, 32'(hold_count), 32'(0));
    check_eq({tag, "_hold_full"}, 32'(hold_full), 32'(0));
  endtask

  task automatic idle_inputs();
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    pkt_valid = 0; fifo_full = 0; rst_int_reg = 0; data_in = '0;
  endtask

  initial begin
    int lf, n;
    logic [DW-1:0] hdr;
    idle_inputs();
    model_reset();
    m_pend_err = 0; m_pend_len = 0; ff_force = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // clean packet
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 0, 0);
    check_eq("clean_err", 32'(err), 32'(0));
    check_eq("clean_len_err", 32'(len_err), 32'(0));

    // corrupt parity, then clean again
    send_pkt(8'h0D, 0, 1);
    check_eq("corrupt_err", 32'(err), 32'(1));
    send_pkt(8'h0D, 0, 0);
    check_eq("recover_err", 32'(err), 32'(0));

    // length mismatch: header declares 4, three payload bytes
    send_pkt(8'h11, 0, 0);
    check_eq("lenmis_len_err", 32'(len_err), 32'(1));
    check_eq("lenmis_err", 32'(err), 32'(0));

    // backpressure on payload bytes 2-3
    ff_force = 16'b0110;
    send_pkt(8'h0D, 0, 0);
    check_eq("bp_hold_max", 32'(max_hold), 32'(2));
    check_eq("bp_len_err", 32'(len_err), 32'(0));

    // overflow: five load bytes with fifo_full held
    ff_force = 16'b11111;
    pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(8'h11, 0, 0);
    check_eq("ovf_sticky", 32'(ovf_err), 32'(1));
    check_eq("ovf_hold_max", 32'(max_hold), 32'(HOLD));
    check_eq("ovf_no_parity_done", 32'(pd_cnt), 32'(0));
    ff_force = '0;
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, 0, 0);
    check_eq("ovf_cleared", 32'(ovf_err), 32'(0));

    // async reset mid-packet with three held bytes
    send_pkt(8'h0D, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h19);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h55);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h66);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h77);
    check_eq("pre_rst_hold", 32'(hold_count), 32'(3));
    check_eq("pre_rst_err", 32'(err), 32'(1));
    idle_inputs();
    #2 resetn = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    send_pkt(8'h0D, 0, 0);
    check_eq("post_rst_err", 32'(err), 32'(0));

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      lf = $urandom_range(0, 6);
      n = lf;
      if ($urandom_range(0, 4) == 0) n = (lf == 0) ? 1 : (($urandom_range(0, 1) == 1) ? lf + 1 : lf - 1);
      hdr = {6'(lf), 2'($urandom_range(0, 2))};
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      ff_force = '0;
      send_pkt(hdr, $urandom_range(0, 60), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
